sata_din_pump: RTL

- Upstream feeder for the SATA stack's user write-data port.
- Accepts a simple valid/ready 32-bit word stream plus a sector count.
- Pushes exactly sector_count*128 words into the stack's ping-pong input FIFO (user_din/stb/ready/activate/size).
- Sits between the user/DMA data source and sata_stack; sata_stack's own write_data_en request is issued separately by the user/command logic, not by this block.

---
 rtl/sata_din_pump_if.sv | 22 ++
 rtl/sata_din_pump.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sata_din_pump_if.sv
// Word-stream and ping-pong FIFO write-side signals of the SATA data pump.
// master is the pump; slave is the source/FIFO side that faces it.
interface sata_din_pump_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] user_din;
  logic        user_din_stb;
  logic [1:0]  user_din_ready;
  logic [1:0]  user_din_activate;
  logic [23:0] user_din_size;

  modport master (
    input  s_data, s_valid, user_din_ready, user_din_size,
    output s_ready, user_din, user_din_stb, user_din_activate
  );

  modport slave (
    output s_data, s_valid, user_din_ready, user_din_size,
    input  s_ready, user_din, user_din_stb, user_din_activate
  );
endinterface

// File: rtl/sata_din_pump.sv
// Feeds sector_count*WORDS_PER_SECTOR words from a valid/ready source into the
// SATA stack's ping-pong write FIFO, one activated half at a time.
module sata_din_pump #(
  parameter int WORDS_PER_SECTOR = 128,
  parameter int COUNT_W          = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        sector_count,
  sata_din_pump_if.master    bus,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] words_sent
);
  localparam int SHIFT = $clog2(WORDS_PER_SECTOR);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACQUIRE, ST_FILL, ST_RELEASE, ST_DONE
  } state_t;

  state_t             state_r, state_n;
  logic [1:0]         activate_r, activate_n;
  logic [23:0]        buf_size_r, buf_size_n;
  logic [23:0]        buf_cnt_r, buf_cnt_n;
  logic [COUNT_W-1:0] remaining_r, remaining_n;
  logic [COUNT_W-1:0] words_sent_r, words_sent_n;
  logic               aborted_r, aborted_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
  logic [COUNT_W-1:0] load_s;
  logic               s_ready_s;
  logic               accept_s;

  // Word count for the new transfer; a zero sector count stands for 65536 sectors.
  always_comb begin
    if (sector_count == 16'd0) begin
      load_s = COUNT_W'(32'h0001_0000) << SHIFT;
    end else begin
      load_s = COUNT_W'(sector_count) << SHIFT;
    end
  end

  // Zero-latency pass-through from the source into the FIFO.
  always_comb begin
    s_ready_s = (state_r == ST_FILL) && (buf_cnt_r < buf_size_r) &&
                (remaining_r != {COUNT_W{1'b0}});
    accept_s  = bus.s_valid && s_ready_s;
  end

  assign bus.s_ready           = s_ready_s;
  assign bus.user_din          = bus.s_data;
  assign bus.user_din_stb      = accept_s;
  assign bus.user_din_activate = activate_r;
  assign busy                  = busy_r;
  assign done                  = done_r;
  assign aborted               = aborted_r;
  assign words_sent            = words_sent_r;

  // Next-state and next-register logic of the transfer FSM.
  always_comb begin
    state_n      = state_r;
    activate_n   = activate_r;
    buf_size_n   = buf_size_r;
    buf_cnt_n    = buf_cnt_r;
    remaining_n  = remaining_r;
    words_sent_n = words_sent_r;
    aborted_n    = aborted_r;
    busy_n       = busy_r;
    done_n       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n      = ST_ACQUIRE;
          busy_n       = 1'b1;
          remaining_n  = load_s;
          words_sent_n = {COUNT_W{1'b0}};
          aborted_n    = 1'b0;
        end else begin
          busy_n = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        busy_n = 1'b1;
        if (abort) begin
          state_n     = ST_RELEASE;
          remaining_n = {COUNT_W{1'b0}};
          aborted_n   = 1'b1;
        end else if ((bus.user_din_ready != 2'b00) && (activate_r == 2'b00)) begin
          activate_n = bus.user_din_ready[0] ? 2'b01 : 2'b10;
          buf_size_n = bus.user_din_size;
          buf_cnt_n  = 24'd0;
          state_n    = ST_FILL;
        end else begin
          state_n = ST_ACQUIRE;
        end
      end
      ST_FILL: begin
        busy_n = 1'b1;
        if (accept_s) begin
          buf_cnt_n    = buf_cnt_r + 24'd1;
          remaining_n  = remaining_r - COUNT_W'(1);
          words_sent_n = words_sent_r + COUNT_W'(1);
        end else begin
          buf_cnt_n = buf_cnt_r;
        end
        // A word taken alongside abort is still counted above.
        if (abort) begin
          state_n     = ST_RELEASE;
          activate_n  = 2'b00;
          remaining_n = {COUNT_W{1'b0}};
          aborted_n   = 1'b1;
        end else if ((buf_cnt_n >= buf_size_r) || (remaining_n == {COUNT_W{1'b0}})) begin
          state_n    = ST_RELEASE;
          activate_n = 2'b00;
        end else begin
          state_n = ST_FILL;
        end
      end
      ST_RELEASE: begin
        activate_n = 2'b00;
        if (remaining_r != {COUNT_W{1'b0}}) begin
          state_n = ST_ACQUIRE;
          busy_n  = 1'b1;
        end else begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      ST_DONE: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: begin
        state_n    = ST_IDLE;
        activate_n = 2'b00;
        busy_n     = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      activate_r   <= 2'b00;
      buf_size_r   <= 24'd0;
      buf_cnt_r    <= 24'd0;
      remaining_r  <= {COUNT_W{1'b0}};
      words_sent_r <= {COUNT_W{1'b0}};
      aborted_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      activate_r   <= activate_n;
      buf_size_r   <= buf_size_n;
      buf_cnt_r    <= buf_cnt_n;
      remaining_r  <= remaining_n;
      words_sent_r <= words_sent_n;
      aborted_r    <= aborted_n;
      busy_r       <= busy_n;
      done_r       <= done_n;
    end
  end
endmodule
